// File: rtl/mod_arith_pkg.sv
// Shared types and helpers for the modular-arithmetic datapath blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mod_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mm_state_t;

  // Bits needed to count iterations 0..width inclusive.
  function automatic int count_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mod_add_reduce.sv
// Modular add: sum = (x + y) mod n, valid when x < n and y < n.
// Latency: combinational, one WIDTH+1-bit add followed by one compare/subtract.
// Backpressure: none; output follows inputs.
module mod_add_reduce #(
  parameter int WIDTH = 256
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] sum
);

  logic [WIDTH:0]   raw;
  logic [WIDTH-1:0] diff;
  logic             wrap;

  // Full-width sum keeps the carry; the subtract only needs the low bits because
  // the reduced value is always below n.
  always_comb begin
    raw  = {1'b0, x} + {1'b0, y};
    diff = raw[WIDTH-1:0] - n;
    wrap = (raw >= {1'b0, n});
    sum  = wrap ? diff : raw[WIDTH-1:0];
  end

endmodule

// File: rtl/mod_mult_interleaved.sv
// Sequential modular multiplier: a*b mod N (mode 0) or a*2^WIDTH mod N (mode 1).
// Latency: WIDTH+1 cycles from accepted start to finish; rejected operands finish after 1 cycle.
// Backpressure: start is only sampled in IDLE; requests while busy are dropped, no queueing.
module mod_mult_interleaved
  import mod_arith_pkg::*;
#(
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] N,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             finish,
  output logic             err,
  output logic [WIDTH-1:0] result
);

  localparam int CW = count_width(WIDTH);

  mm_state_t        state;
  logic [WIDTH-1:0] n_r;
  logic [WIDTH-1:0] t_r;
  logic [WIDTH-1:0] m_r;
  logic [WIDTH:0]   mul_r;
  logic [CW-1:0]    cnt_r;

  logic [WIDTH-1:0] m_add;
  logic [WIDTH-1:0] t_dbl;
  logic [WIDTH-1:0] m_next;
  logic             last_iter;
  logic             reject;

  // Accumulate path: m + t mod N.
  mod_add_reduce #(.WIDTH(WIDTH)) u_add_mt (
    .x   (m_r),
    .y   (t_r),
    .n   (n_r),
    .sum (m_add)
  );

  // Doubling path: t + t mod N.
  mod_add_reduce #(.WIDTH(WIDTH)) u_add_tt (
    .x   (t_r),
    .y   (t_r),
    .n   (n_r),
    .sum (t_dbl)
  );

  // Iteration decode. Operand validation reads the latched copies (t still holds a
  // on the first RUN cycle), keeping the wide comparators off the input pins; a
  // rejected request therefore reports one cycle after acceptance.
  always_comb begin
    m_next    = mul_r[0] ? m_add : m_r;
    last_iter = (cnt_r == CW'(WIDTH));
    reject    = (n_r[WIDTH-1:1] == '0) || (t_r >= n_r);
  end

  // Control FSM plus datapath registers; busy/finish are registered alongside state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      n_r    <= '0;
      t_r    <= '0;
      m_r    <= '0;
      mul_r  <= '0;
      cnt_r  <= '0;
      busy   <= 1'b0;
      finish <= 1'b0;
      err    <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          finish <= 1'b0;
          if (start) begin
            n_r   <= N;
            t_r   <= a;
            m_r   <= '0;
            cnt_r <= '0;
            mul_r <= mode ? {1'b1, {WIDTH{1'b0}}} : {1'b0, b};
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          if ((cnt_r == '0) && reject) begin
            err    <= 1'b1;
            result <= '0;
            finish <= 1'b1;
            state  <= DONE;
          end else begin
            m_r   <= m_next;
            t_r   <= t_dbl;
            mul_r <= mul_r >> 1;
            cnt_r <= cnt_r + CW'(1);
            if (last_iter) begin
              result <= m_next;
              err    <= 1'b0;
              finish <= 1'b1;
              state  <= DONE;
            end
          end
        end
        DONE: begin
          finish <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          finish <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mod_mult_interleaved.sv
// Self-checking bench for mod_mult_interleaved at WIDTH 8 (directed + random) and WIDTH 256 (random).
// Latency: checks WIDTH+1 cycles for valid requests and 1 cycle for rejected ones.
// Backpressure: exercises start pulses during RUN and DONE, which must be ignored.
module tb_mod_mult_interleaved;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       start8, mode8, busy8, fin8, err8;
  logic [7:0] n8, a8, b8, res8;

  logic         start256, mode256, busy256, fin256, err256;
  logic [255:0] n256, a256, b256, res256;

  int checks = 0;
  int passes = 0;

  mod_mult_interleaved #(.WIDTH(8)) dut8 (
    .clk    (clk),
    .rst    (rst),
    .start  (start8),
    .mode   (mode8),
    .N      (n8),
    .a      (a8),
    .b      (b8),
    .busy   (busy8),
    .finish (fin8),
    .err    (err8),
    .result (res8)
  );

  mod_mult_interleaved #(.WIDTH(256)) dut256 (
    .clk    (clk),
    .rst    (rst),
    .start  (start256),
    .mode   (mode256),
    .N      (n256),
    .a      (a256),
    .b      (b256),
    .busy   (busy256),
    .finish (fin256),
    .err    (err256),
    .result (res256)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference: plain integer product reduced by %.
  function automatic logic [7:0] ref8(input logic md, input logic [7:0] nn, input logic [7:0] aa,
                                      input logic [7:0] bb);
    int unsigned p;
    p = md ? (int'(aa) * 256) : (int'(aa) * int'(bb));
    return 8'(p % int'(nn));
  endfunction

  function automatic logic [255:0] ref256(input logic md, input logic [255:0] nn,
                                          input logic [255:0] aa, input logic [255:0] bb);
    logic [511:0] p;
    logic [511:0] r;
    p = md ? ({256'b0, aa} << 256) : ({256'b0, aa} * {256'b0, bb});
    r = p % {256'b0, nn};
    return r[255:0];
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // One WIDTH-8 request. poke_run > 0 pulses start in that RUN cycle; poke_done pulses it in DONE.
  task automatic run8(input string tag, input logic md, input logic [7:0] nn, input logic [7:0] aa,
                      input logic [7:0] bb, input int poke_run, input bit poke_done);
    logic [7:0] er;
    logic       ee;
    int         el;
    int         lat;
    ee = (nn < 8'd2) || (aa >= nn);
    er = ee ? 8'd0 : ref8(md, nn, aa, bb);
    el = ee ? 1 : 9;
    mode8 = md; n8 = nn; a8 = aa; b8 = bb; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    n8 = 8'($urandom); a8 = 8'($urandom); b8 = 8'($urandom); mode8 = 1'($urandom);
    check({tag, ".busy_rise"}, busy8, 1);
    lat = 0;
    while (!fin8 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      start8 = (lat == poke_run) && !fin8;
    end
    start8 = 1'b0;
    check({tag, ".latency"}, lat, el);
    check({tag, ".result"}, res8, er);
    check({tag, ".err"}, err8, ee);
    if (poke_done) start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    check({tag, ".finish_pulse"}, fin8, 0);
    check({tag, ".busy_fall"}, busy8, 0);
    check({tag, ".result_hold"}, res8, er);
  endtask

  task automatic run256(input string tag, input logic md, input logic [255:0] nn,
                        input logic [255:0] aa, input logic [255:0] bb);
    logic [255:0] er;
    int           lat;
    er = ref256(md, nn, aa, bb);
    mode256 = md; n256 = nn; a256 = aa; b256 = bb; start256 = 1'b1;
    @(posedge clk); #1;
    start256 = 1'b0;
    n256 = rand256(); a256 = rand256(); b256 = rand256();
    check({tag, ".busy_rise"}, busy256, 1);
    lat = 0;
    while (!fin256 && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".latency"}, lat, 257);
    check({tag, ".result"}, res256, er);
    check({tag, ".err"}, err256, 0);
    @(posedge clk); #1;
    check({tag, ".busy_fall"}, busy256, 0);
  endtask

  initial begin
    rst = 1'b1;
    start8 = 1'b0; mode8 = 1'b0; n8 = '0; a8 = '0; b8 = '0;
    start256 = 1'b0; mode256 = 1'b0; n256 = '0; a256 = '0; b256 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.busy", busy8, 0);
    check("rst.finish", fin8, 0);
    check("rst.err", err8, 0);
    check("rst.result", res8, 0);
    check("rst.busy256", busy256, 0);
    check("rst.result256", res256, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed WIDTH-8 cases.
    run8("mul_200x100", 1'b0, 8'd251, 8'd200, 8'd100, 0, 1'b0);
    check("mul_200x100.const", res8, 171);
    run8("prescale_200", 1'b1, 8'd251, 8'd200, 8'hFF, 0, 1'b0);
    check("prescale_200.const", res8, 247);
    run8("max_250x250", 1'b0, 8'd251, 8'd250, 8'd250, 0, 1'b0);
    check("max_250x250.const", res8, 1);
    run8("a_zero", 1'b0, 8'd251, 8'd0, 8'd77, 0, 1'b0);
    run8("b_zero", 1'b0, 8'd251, 8'd99, 8'd0, 0, 1'b0);
    run8("rej_a_eq_n", 1'b0, 8'd251, 8'd251, 8'd5, 0, 1'b0);
    run8("rej_n_one", 1'b0, 8'd1, 8'd0, 8'd5, 0, 1'b0);
    run8("after_rej", 1'b0, 8'd13, 8'd7, 8'd11, 0, 1'b0);
    run8("start_ignored", 1'b0, 8'd239, 8'd123, 8'd201, 3, 1'b1);

    // Reset during RUN cycle 4 must clear every output on the next cycle.
    mode8 = 1'b0; n8 = 8'd251; a8 = 8'd123; b8 = 8'd45; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midrun.busy_before", busy8, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrun_rst.busy", busy8, 0);
    check("midrun_rst.finish", fin8, 0);
    check("midrun_rst.err", err8, 0);
    check("midrun_rst.result", res8, 0);
    run8("after_rst", 1'b0, 8'd251, 8'd123, 8'd45, 0, 1'b0);

    // Random WIDTH-8 requests, including rejected operands.
    for (int i = 0; i < 40; i++) begin
      logic [7:0] rn, ra, rb;
      rn = 8'($urandom);
      rb = 8'($urandom);
      if (i % 8 == 7) ra = 8'($urandom);
      else ra = (rn > 8'd1) ? 8'($urandom % int'(rn)) : 8'd0;
      run8($sformatf("rand8_%0d", i), 1'($urandom), rn, ra, rb, 0, 1'b0);
    end

    // Random WIDTH-256 requests, odd N >= 3, both modes.
    for (int i = 0; i < 150; i++) begin
      logic [255:0] rn, ra, rb;
      rn = rand256();
      rn[0] = 1'b1;
      if (rn < 256'd3) rn = 256'd3;
      ra = rand256() % rn;
      rb = rand256();
      run256($sformatf("rand256_%0d", i), 1'(i % 2), rn, ra, rb);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
